// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port, with sticky trap, optional memory timeout and a retired-instruction count.
module multicycle_control #(
  parameter bit          SUPPORT_SRA = 1'b1,
  parameter bit          SUPPORT_MEM = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             reg_we,
  output logic             wb_sel,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src,
  output logic             trap,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] retire_cnt_q;
  logic             retire;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_br, alt_f7, sra_bad, legal, to_hit;
  logic [3:0] op_alu;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  // Instruction class, legality and ALU operation from the IR
  always_comb begin
    is_r    = (opcode == OP_R);
    is_i    = (opcode == OP_I);
    is_ld   = SUPPORT_MEM && (opcode == OP_LD);
    is_st   = SUPPORT_MEM && (opcode == OP_ST);
    is_br   = (opcode == OP_BR) && (funct3[2:1] == 2'b00);
    alt_f7  = (funct7 == 7'b0100000);
    sra_bad = (is_r || is_i) && (funct3 == 3'b101) && alt_f7 && !SUPPORT_SRA;
    legal   = (is_r || is_i || is_ld || is_st || is_br) && !sra_bad;
    op_alu  = ALU_ADD;
    if (is_br) begin
      op_alu = ALU_SUB;
    end else if (is_r || is_i) begin
      unique case (funct3)
        3'b000:  op_alu = (is_r && alt_f7) ? ALU_SUB : ALU_ADD;
        3'b001:  op_alu = ALU_SLL;
        3'b010:  op_alu = ALU_SLT;
        3'b011:  op_alu = ALU_SLTU;
        3'b100:  op_alu = ALU_XOR;
        3'b101:  op_alu = alt_f7 ? ALU_SRA : ALU_SRL;
        3'b110:  op_alu = ALU_OR;
        default: op_alu = ALU_AND;
      endcase
    end
  end

  // Timeout fires on the Nth consecutive unanswered request cycle; a same-cycle ready wins
  assign to_hit = (MEM_TIMEOUT != 0) && !mem_ready && (to_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_src   = 1'b0;
    trap      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_DECODE;
          end else if (to_hit) begin
            state_d = S_TRAP;
          end
        end
        S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          alu_ctrl = op_alu;
          alu_src  = is_i || is_ld || is_st;
          if (is_br) begin
            pc_branch = funct3[0] ^ alu_zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end else if (is_ld || is_st) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_st;
          if (mem_ready) begin
            retire  = is_st;
            state_d = is_st ? S_FETCH : S_WB;
          end else if (to_hit) begin
            state_d = S_TRAP;
          end
        end
        S_WB: begin
          reg_we  = 1'b1;
          wb_sel  = is_ld;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_TRAP:  trap = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
    if (state_d != state_q) begin
      to_d = '0;
    end else if (mem_req && !mem_ready && (MEM_TIMEOUT != 0)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      to_q         <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      if (retire) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three parameterisations share inputs; a selector picks the
// instance under test. Directed table, hand sequences and random instructions vs a reference model.
module tb_multicycle_control;

  localparam int C_ILL = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BEQ = 5, C_BNE = 6;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] ins;
    bit          az;
    int          cls;
    logic [3:0]  alu;
    int          fw;
    int          mw;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, alu_zero;
  logic [2:0]  mem_req_w, mem_we_w, addr_sel_w, ir_we_w, pc_inc_w, pc_branch_w;
  logic [2:0]  reg_we_w, wb_sel_w, alu_src_w, trap_w;
  logic [3:0]  alu_w [3];
  logic [31:0] ret0, ret1;
  logic [2:0]  ret2;
  logic [1:0]  sel;
  logic [13:0] obs;
  logic [31:0] ret_obs;
  logic [31:0] exp_retire;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  multicycle_control u_dut0 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req_w[0]), .mem_we(mem_we_w[0]), .addr_sel(addr_sel_w[0]), .ir_we(ir_we_w[0]),
    .pc_inc(pc_inc_w[0]), .pc_branch(pc_branch_w[0]), .reg_we(reg_we_w[0]), .wb_sel(wb_sel_w[0]),
    .alu_ctrl(alu_w[0]), .alu_src(alu_src_w[0]), .trap(trap_w[0]), .retire_cnt(ret0)
  );

  multicycle_control #(.SUPPORT_SRA(1'b0), .SUPPORT_MEM(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req_w[1]), .mem_we(mem_we_w[1]), .addr_sel(addr_sel_w[1]), .ir_we(ir_we_w[1]),
    .pc_inc(pc_inc_w[1]), .pc_branch(pc_branch_w[1]), .reg_we(reg_we_w[1]), .wb_sel(wb_sel_w[1]),
    .alu_ctrl(alu_w[1]), .alu_src(alu_src_w[1]), .trap(trap_w[1]), .retire_cnt(ret1)
  );

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req_w[2]), .mem_we(mem_we_w[2]), .addr_sel(addr_sel_w[2]), .ir_we(ir_we_w[2]),
    .pc_inc(pc_inc_w[2]), .pc_branch(pc_branch_w[2]), .reg_we(reg_we_w[2]), .wb_sel(wb_sel_w[2]),
    .alu_ctrl(alu_w[2]), .alu_src(alu_src_w[2]), .trap(trap_w[2]), .retire_cnt(ret2)
  );

  always_comb begin
    obs = {trap_w[sel], mem_req_w[sel], mem_we_w[sel], addr_sel_w[sel], ir_we_w[sel],
           pc_inc_w[sel], pc_branch_w[sel], reg_we_w[sel], wb_sel_w[sel], alu_src_w[sel], alu_w[sel]};
    unique case (sel)
      2'd0:    ret_obs = ret0;
      2'd1:    ret_obs = ret1;
      default: ret_obs = 32'(ret2);
    endcase
  end

  function automatic logic [13:0] ob(input bit req, we, asel, irwe, pcinc, pcbr, regwe, wbs, src, trp,
                                      input logic [3:0] alu);
    return {trp, req, we, asel, irwe, pcinc, pcbr, regwe, wbs, src, alu};
  endfunction

  // Reference decode written from the ISA rules (class + ALU op)
  function automatic void ref_decode(input logic [31:0] ins, input bit sra_ok, input bit mem_ok,
                                     output int cls, output logic [3:0] alu);
    logic [3:0] amap [8];
    logic [6:0] op;
    logic [2:0] f3;
    bit         alt;
    amap = '{4'd0, 4'd2, 4'd3, 4'd9, 4'd4, 4'd5, 4'd6, 4'd7};
    op   = ins[6:0];
    f3   = ins[14:12];
    alt  = (ins[31:25] == 7'h20);
    cls  = C_ILL;
    alu  = 4'd0;
    case (op)
      7'h33, 7'h13: begin
        cls = (op == 7'h33) ? C_R : C_I;
        alu = amap[f3];
        if (f3 == 3'd0 && alt && cls == C_R) alu = 4'd1;
        if (f3 == 3'd5 && alt) begin
          if (sra_ok) alu = 4'd8;
          else cls = C_ILL;
        end
      end
      7'h03: cls = mem_ok ? C_LD : C_ILL;
      7'h23: cls = mem_ok ? C_ST : C_ILL;
      7'h63: begin
        alu = 4'd1;
        if (f3 == 3'd0) cls = C_BEQ;
        else if (f3 == 3'd1) cls = C_BNE;
      end
      default: ;
    endcase
  endfunction

  function automatic int ref_lat(input int cls, input int fw, input int mw);
    case (cls)
      C_ILL:        return fw + 2;
      C_BEQ, C_BNE: return fw + 3;
      C_LD:         return fw + mw + 5;
      C_ST:         return fw + mw + 4;
      default:      return fw + 4;
    endcase
  endfunction

  task automatic step(input logic [13:0] exp, input string nm);
    #1;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %b expected %b (trap,req,we,asel,irwe,pcinc,pcbr,regwe,wbsel,src,alu)",
               nm, obs, exp);
    end
    @(negedge clk);
  endtask

  task automatic chk_ret(input string nm);
    logic [31:0] e;
    e = (sel == 2'd2) ? (exp_retire & 32'd7) : exp_retire;
    n_cmp++;
    if (ret_obs !== e) begin
      n_bad++;
      $display("FAIL %s: retire_cnt got %0d expected %0d", nm, ret_obs, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    exp_retire = 32'd0;
    #1;
    n_cmp++;
    if (obs !== 14'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected all zero", obs);
    end
    chk_ret("reset_retire");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one instruction through the selected DUT, checking every cycle
  task automatic run_instr(input logic [31:0] ins, input bit az, input int cls, input logic [3:0] alu,
                           input int fw, input int mw, output int lat);
    bit src, br, ld, st;
    src = (cls == C_I) || (cls == C_LD) || (cls == C_ST);
    br  = ((cls == C_BEQ) && az) || ((cls == C_BNE) && !az);
    ld  = (cls == C_LD);
    st  = (cls == C_ST);
    instr = ins;
    alu_zero = az;
    lat = 0;
    for (int w = 0; w < fw; w++) begin
      mem_ready = 1'b0;
      step(ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "fetch_wait");
      lat++;
    end
    mem_ready = 1'b1;
    step(ob(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'd0), "fetch");
    lat++;
    mem_ready = 1'($urandom);
    step(14'd0, "decode");
    lat++;
    if (cls == C_ILL) begin
      for (int t = 0; t < 2; t++) begin
        mem_ready = 1'($urandom);
        step(ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0), "trap_sticky");
      end
      chk_ret("trap_frozen");
      do_reset();
      return;
    end
    mem_ready = 1'($urandom);
    step(ob(0, 0, 0, 0, 0, br, 0, 0, src, 0, alu), "exec");
    lat++;
    if (ld || st) begin
      for (int w = 0; w < mw; w++) begin
        mem_ready = 1'b0;
        step(ob(1, st, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0), "mem_wait");
        lat++;
      end
      mem_ready = 1'b1;
      step(ob(1, st, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0), "mem");
      lat++;
    end
    if (!(st || cls == C_BEQ || cls == C_BNE)) begin
      mem_ready = 1'($urandom);
      step(ob(0, 0, 0, 0, 0, 0, 1, ld, 0, 0, 4'd0), "wb");
      lat++;
    end
    exp_retire = exp_retire + 32'd1;
    chk_ret("retire");
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    instr = 32'd0;
    mem_ready = 1'b0;
    alu_zero = 1'b0;
    sel = 2'd0;
    exp_retire = 32'd0;

    // sel, instr, alu_zero, class, alu_ctrl, fetch wait, mem wait, latency
    tbl.push_back('{2'd0, 32'h002081B3, 1'b0, C_R,   4'd0, 0, 0, 4});   // add
    tbl.push_back('{2'd0, 32'h402081B3, 1'b0, C_R,   4'd1, 0, 0, 4});   // sub
    tbl.push_back('{2'd0, 32'h4020D1B3, 1'b0, C_R,   4'd8, 0, 0, 4});   // sra
    tbl.push_back('{2'd0, 32'h0020B1B3, 1'b0, C_R,   4'd9, 0, 0, 4});   // sltu
    tbl.push_back('{2'd0, 32'h00500093, 1'b0, C_I,   4'd0, 0, 0, 4});   // addi
    tbl.push_back('{2'd0, 32'h40000093, 1'b0, C_I,   4'd0, 0, 0, 4});   // addi, imm looks like funct7=0100000
    tbl.push_back('{2'd0, 32'h4030D093, 1'b0, C_I,   4'd8, 0, 0, 4});   // srai
    tbl.push_back('{2'd0, 32'h0030D093, 1'b0, C_I,   4'd5, 0, 0, 4});   // srli
    tbl.push_back('{2'd0, 32'h0FF0C093, 1'b0, C_I,   4'd4, 0, 0, 4});   // xori
    tbl.push_back('{2'd0, 32'h00012083, 1'b0, C_LD,  4'd0, 0, 0, 5});   // lw
    tbl.push_back('{2'd0, 32'h00012083, 1'b0, C_LD,  4'd0, 0, 3, 8});   // lw, 3 wait cycles
    tbl.push_back('{2'd0, 32'h00112023, 1'b0, C_ST,  4'd0, 0, 0, 4});   // sw
    tbl.push_back('{2'd0, 32'h00208463, 1'b1, C_BEQ, 4'd1, 0, 0, 3});   // beq taken
    tbl.push_back('{2'd0, 32'h00208463, 1'b0, C_BEQ, 4'd1, 0, 0, 3});   // beq not taken
    tbl.push_back('{2'd0, 32'h00209463, 1'b0, C_BNE, 4'd1, 0, 0, 3});   // bne taken
    tbl.push_back('{2'd0, 32'h00209463, 1'b1, C_BNE, 4'd1, 0, 0, 3});   // bne not taken
    tbl.push_back('{2'd0, 32'h0020C463, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // blt
    tbl.push_back('{2'd0, 32'h0000006F, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // jal
    tbl.push_back('{2'd0, 32'h00000000, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // all zero
    tbl.push_back('{2'd1, 32'h4030D093, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // srai without sra
    tbl.push_back('{2'd1, 32'h4020D1B3, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // sra without sra
    tbl.push_back('{2'd1, 32'h00012083, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // lw without mem
    tbl.push_back('{2'd1, 32'h00112023, 1'b0, C_ILL, 4'd0, 0, 0, 2});   // sw without mem
    tbl.push_back('{2'd1, 32'h0030D093, 1'b0, C_I,   4'd5, 0, 0, 4});   // srli still legal
    tbl.push_back('{2'd1, 32'h402081B3, 1'b0, C_R,   4'd1, 0, 0, 4});   // sub still legal
    tbl.push_back('{2'd2, 32'h002081B3, 1'b0, C_R,   4'd0, 3, 0, 7});   // ready on 4th fetch cycle
    tbl.push_back('{2'd2, 32'h00012083, 1'b0, C_LD,  4'd0, 3, 3, 11});  // counter clears entering MEM

    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel != sel) begin
        sel = tbl[i].sel;
        do_reset();
      end
      run_instr(tbl[i].ins, tbl[i].az, tbl[i].cls, tbl[i].alu, tbl[i].fw, tbl[i].mw, lat);
      n_cmp++;
      if (lat != tbl[i].lat) begin
        n_bad++;
        $display("FAIL latency vec%0d: got %0d expected %0d", i, lat, tbl[i].lat);
      end
    end

    // Fetch timeout: 4 unanswered request cycles trap, and trap is sticky
    sel = 2'd2;
    do_reset();
    mem_ready = 1'b0;
    for (int w = 0; w < 4; w++) step(ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "to_fetch_wait");
    step(ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0), "to_trap");
    mem_ready = 1'b1;
    step(ob(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0), "to_trap_sticky");
    chk_ret("to_trap_frozen");
    do_reset();

    // 3-bit retire counter wraps
    for (int n = 0; n < 9; n++) run_instr(32'h00500093, 1'b0, C_I, 4'd0, 0, 0, lat);

    // Random instructions against the reference model
    sel = 2'd0;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      logic [3:0]  alu;
      int          cls, fw, mw;
      bit          az;
      ins = $urandom;
      case ($urandom_range(0, 6))
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        2: ins[6:0] = 7'h03;
        3: ins[6:0] = 7'h23;
        4: ins[6:0] = 7'h63;
        5: begin ins[6:0] = 7'h63; ins[14:13] = 2'b00; end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      az = 1'($urandom);
      fw = int'($urandom_range(0, 3));
      mw = int'($urandom_range(0, 3));
      ref_decode(ins, 1'b1, 1'b1, cls, alu);
      run_instr(ins, az, cls, alu, fw, mw, lat);
      n_cmp++;
      if (lat != ref_lat(cls, fw, mw)) begin
        n_bad++;
        $display("FAIL rand_latency %0d instr %h: got %0d expected %0d", n, ins, lat, ref_lat(cls, fw, mw));
      end
    end

    // Reset in the middle of a store's memory phase
    run_instr(32'h002081B3, 1'b0, C_R, 4'd0, 0, 0, lat);
    instr = 32'h00112023;
    alu_zero = 1'b0;
    mem_ready = 1'b1;
    step(ob(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'd0), "sw_fetch");
    mem_ready = 1'b0;
    step(14'd0, "sw_decode");
    step(ob(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0), "sw_exec");
    step(ob(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0), "sw_mem_wait");
    do_reset();
    mem_ready = 1'b0;
    step(ob(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "post_rst_fetch");
    chk_ret("post_rst_retire");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
